// File: rtl/uart_rx_module_if.sv
// Serial receive bundle: the line/enable toward the receiver and the byte/strobes back to the consumer.
interface uart_rx_module_if;
  logic       RX_Pin_In;
  logic       RX_En_Sig;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       RX_Err_Sig;

  modport master (
    output RX_Pin_In,
    output RX_En_Sig,
    input  RX_Data,
    input  RX_Done_Sig,
    input  RX_Err_Sig
  );

  modport slave (
    input  RX_Pin_In,
    input  RX_En_Sig,
    output RX_Data,
    output RX_Done_Sig,
    output RX_Err_Sig
  );
endinterface

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: 3-flop synchronizer, mid-bit sampling, start-glitch rejection,
// registered byte output with one-cycle done / framing-error strobes.
module uart_rx_module #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic             CLK,
  input  logic             RST,
  uart_rx_module_if.slave  rx
);

  localparam int BPS  = CLK_FREQ / BAUD;
  localparam int HALF = BPS / 2;
  localparam int CW   = $clog2(BPS);

  localparam logic [CW-1:0] BPS_M1  = CW'(BPS - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s3_q, s3_d;
  logic          fall_s;

  assign fall_s = s3_q & ~s2_q;

  // Next-state and datapath: counter, bit index, shift register and strobes.
  always_comb begin
    s1_d      = rx.RX_Pin_In;
    s2_d      = s1_q;
    s3_d      = s2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (rx.RX_En_Sig && fall_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        // Mid start bit: a line already back high means the edge was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d     = {CW{1'b0}};
          bit_idx_d = 3'd0;
          if (!s2_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == BPS_M1) begin
          shift_d[bit_idx_q] = s2_q;
          cnt_d              = {CW{1'b0}};
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == BPS_M1) begin
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
          if (s2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
    end
  end

  assign rx.RX_Data     = data_q;
  assign rx.RX_Done_Sig = done_q;
  assign rx.RX_Err_Sig  = err_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Scoreboard bench for uart_rx_module at BPS=16: stimulus pushes expected strobes,
// a negedge monitor pops and checks kind, byte and arrival cycle.
module tb_uart_rx_module;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  uart_rx_module_if rx_if();

  uart_rx_module #(
    .CLK_FREQ (16),
    .BAUD     (1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .rx  (rx_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one 8N1 frame from a negedge; kind 0 = no strobe, 1 = done, 2 = framing error.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int kind);
    exp_t e;
    if (kind != 0) begin
      e.is_err = (kind == 2);
      e.data   = d;
      e.cyc    = cyc + 155;
      exp_q.push_back(e);
    end
    rx_if.RX_Pin_In = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.RX_Pin_In = d[i];
      repeat (16) @(negedge clk);
    end
    rx_if.RX_Pin_In = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rx_if.RX_Done_Sig || rx_if.RX_Err_Sig) begin
      check("strobe_exclusive", int'(rx_if.RX_Done_Sig & rx_if.RX_Err_Sig), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind_err", int'(rx_if.RX_Err_Sig), int'(e.is_err));
        check("strobe_cycle", cyc, e.cyc);
        if (!e.is_err) begin
          check("rx_data", int'(rx_if.RX_Data), int'(e.data));
        end
      end
    end
  end

  initial begin
    cyc             = 0;
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    rx_if.RX_Pin_In = 1'b1;
    rx_if.RX_En_Sig = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("reset_data", int'(rx_if.RX_Data), 8'h00);
    check("reset_done", int'(rx_if.RX_Done_Sig), 0);
    check("reset_err", int'(rx_if.RX_Err_Sig), 0);
    repeat (5) @(negedge clk);

    // Good frame, then back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b1, 1);
    repeat (20) @(negedge clk);
    send_frame(8'hA3, 1'b1, 1);
    send_frame(8'h0F, 1'b1, 1);
    repeat (20) @(negedge clk);

    // Three-cycle low glitch must be rejected.
    rx_if.RX_Pin_In = 1'b0;
    repeat (3) @(negedge clk);
    rx_if.RX_Pin_In = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_data_held", int'(rx_if.RX_Data), 8'h0F);

    // Framing error, with the line left low afterwards as a break.
    send_frame(8'h3C, 1'b0, 2);
    repeat (200) @(negedge clk);
    rx_if.RX_Pin_In = 1'b1;
    repeat (20) @(negedge clk);
    check("err_data_held", int'(rx_if.RX_Data), 8'h0F);

    // Enable gating: disabled frame ignored; enable with the next start bit, drop mid-frame.
    rx_if.RX_En_Sig = 1'b0;
    send_frame(8'h77, 1'b1, 0);
    check("disabled_data_held", int'(rx_if.RX_Data), 8'h0F);
    rx_if.RX_En_Sig = 1'b1;
    fork
      send_frame(8'h81, 1'b1, 1);
      begin
        repeat (60) @(negedge clk);
        rx_if.RX_En_Sig = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("enable_frame_data", int'(rx_if.RX_Data), 8'h81);
    rx_if.RX_En_Sig = 1'b1;

    // Reset during data bit 4 aborts silently and clears the byte.
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("reset_midframe_data", int'(rx_if.RX_Data), 8'h00);
    send_frame(8'h12, 1'b1, 1);
    repeat (40) @(negedge clk);
    check("final_data", int'(rx_if.RX_Data), 8'h12);

    check("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
